// File: rtl/click_event_queue_if.sv
// Click event handshake bus: the queue drives the head event, the consumer drives evt_ready.
interface click_event_queue_if #(
  parameter int unsigned XW = 9,
  parameter int unsigned YW = 10
);
  logic          evt_valid;
  logic [XW-1:0] evt_x;
  logic [YW-1:0] evt_y;
  logic          evt_ready;

  modport master (output evt_valid, evt_x, evt_y, input evt_ready);
  modport slave  (input evt_valid, evt_x, evt_y, output evt_ready);
endinterface

// File: rtl/click_event_queue.sv
// Conditions the raw click level, queues one clamped-coordinate event per press and holds a
// frame-stable cursor. Define CLICK_DEBOUNCE_EN to enable the debounce counter.
module click_event_queue #(
  parameter int unsigned CANVAS_WIDTH    = 360,
  parameter int unsigned CANVAS_HEIGHT   = 720,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              new_frame,
  input  logic [$clog2(CANVAS_WIDTH)-1:0]   mouse_x,
  input  logic [$clog2(CANVAS_HEIGHT)-1:0]  mouse_y,
  input  logic                              click,
  output logic [$clog2(CANVAS_WIDTH)-1:0]   cursor_x,
  output logic [$clog2(CANVAS_HEIGHT)-1:0]  cursor_y,
  click_event_queue_if.master               evt,
  output logic [$clog2(DEPTH):0]            evt_count,
  output logic                              overflow
);
  localparam int unsigned XW = $clog2(CANVAS_WIDTH);
  localparam int unsigned YW = $clog2(CANVAS_HEIGHT);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } evt_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("click_event_queue: DEPTH must be a power of two >= 2, DEBOUNCE_CYCLES >= 2");
  end

  logic [XW-1:0] cx_c;
  logic [YW-1:0] cy_c;
  evt_t          new_evt_c;
  logic          db_q, db_d, db_dly_q;
  logic          push_req_c, full_c, pop_c, push_c;
  logic [XW-1:0] cursor_x_q, cursor_x_d;
  logic [YW-1:0] cursor_y_q, cursor_y_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  evt_t          head_q, head_d;
  evt_t          mem_q [DEPTH];

  // Canvas clamp of the live mouse position
  always_comb begin
    cx_c      = (32'(mouse_x) >= CANVAS_WIDTH)  ? XW'(CANVAS_WIDTH - 1)  : mouse_x;
    cy_c      = (32'(mouse_y) >= CANVAS_HEIGHT) ? YW'(CANVAS_HEIGHT - 1) : mouse_y;
    new_evt_c = '{x: cx_c, y: cy_c};
  end

`ifdef CLICK_DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
  logic [DBW-1:0] cnt_q, cnt_d;

  // Level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (click != db_q) begin
      if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) db_d = ~db_q;
      else                                    cnt_d = cnt_q + DBW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb db_d = click;
`endif

  always_comb begin
    cursor_x_d = cursor_x_q;
    cursor_y_d = cursor_y_q;
    if (new_frame) begin
      cursor_x_d = cx_c;
      cursor_y_d = cy_c;
    end

    push_req_c = db_q & ~db_dly_q;
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = valid_q & evt.evt_ready;
    push_c     = push_req_c & (~full_c | pop_c);
    overflow_d = overflow_q | (push_req_c & full_c & ~pop_c);

    wr_ptr_d = wr_ptr_q + AW'(push_c);
    rd_ptr_d = rd_ptr_q + AW'(pop_c);
    count_d  = count_q + CW'(push_c) - CW'(pop_c);
    valid_d  = (count_d != '0);

    // Head register tracks the entry at the next read pointer, including one written this cycle
    if (push_c && (wr_ptr_q == rd_ptr_d)) head_d = new_evt_c;
    else                                  head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cursor_x_q <= '0;
      cursor_y_q <= '0;
      db_q       <= 1'b0;
      db_dly_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      head_q     <= '0;
    end else begin
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      db_q       <= db_d;
      db_dly_q   <= db_q;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      head_q     <= head_d;
    end
  end

  // Storage is not reset; the pointers define which entries are live
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_c) mem_q[wr_ptr_q] <= new_evt_c;
  end

  assign cursor_x      = cursor_x_q;
  assign cursor_y      = cursor_y_q;
  assign evt.evt_valid = valid_q;
  assign evt.evt_x     = head_q.x;
  assign evt.evt_y     = head_q.y;
  assign evt_count     = count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_click_event_queue.sv
// Self-checking bench for click_event_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model. Honours CLICK_DEBOUNCE_EN.
module tb_click_event_queue;
  localparam int unsigned W     = 360;
  localparam int unsigned H     = 720;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DBC   = 16;
  localparam int unsigned XW    = $clog2(W);
  localparam int unsigned YW    = $clog2(H);
`ifdef CLICK_DEBOUNCE_EN
  localparam int LAT         = DBC;
  localparam int GLITCH_EVTS = 0;
`else
  localparam int LAT         = 1;
  localparam int GLITCH_EVTS = 1;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                new_frame;
  logic [XW-1:0]       mouse_x, cursor_x;
  logic [YW-1:0]       mouse_y, cursor_y;
  logic                click;
  logic [$clog2(DEPTH):0] evt_count;
  logic                overflow;

  click_event_queue_if #(.XW(XW), .YW(YW)) evt_if ();

  click_event_queue #(
    .CANVAS_WIDTH(W), .CANVAS_HEIGHT(H), .DEPTH(DEPTH), .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk_in(clk), .rst_in(rst), .new_frame(new_frame),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .click(click),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .evt(evt_if),
    .evt_count(evt_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input int v, input int lim);
    return (v >= lim) ? lim - 1 : v;
  endfunction

  // Reference model: event queue, debounced level from a sample history, sticky overflow
  typedef struct { int x; int y; } mev_t;
  mev_t m_q[$];
  bit   m_hist[$];
  bit   m_db, m_rise, m_ovf;
  int   m_cx, m_cy;

  always @(posedge clk) begin : model
    bit old_db;
    bit all_diff;
    if (rst) begin
      m_q.delete();
      m_hist.delete();
      m_db = 0; m_rise = 0; m_ovf = 0; m_cx = 0; m_cy = 0;
    end else begin
      if (m_q.size() != 0 && evt_if.evt_ready) m_q.delete(0);
      if (m_rise) begin
        if (m_q.size() < DEPTH) m_q.push_back('{clampv(int'(mouse_x), W), clampv(int'(mouse_y), H)});
        else m_ovf = 1;
      end
      old_db = m_db;
`ifdef CLICK_DEBOUNCE_EN
      m_hist.push_back(click);
      if (m_hist.size() > DBC) m_hist.delete(0);
      all_diff = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 0;
      if (m_hist.size() == DBC && all_diff) begin
        m_db = !m_db;
        m_hist.delete();
      end
`else
      all_diff = 0;
      m_db = click;
`endif
      m_rise = m_db && !old_db;
      if (new_frame) begin
        m_cx = clampv(int'(mouse_x), W);
        m_cy = clampv(int'(mouse_y), H);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_count", 32'(evt_count), m_q.size());
      chk("cyc_valid", 32'(evt_if.evt_valid), (m_q.size() != 0) ? 1 : 0);
      chk("cyc_ovf", 32'(overflow), m_ovf ? 1 : 0);
      chk("cyc_cx", 32'(cursor_x), m_cx);
      chk("cyc_cy", 32'(cursor_y), m_cy);
      if (m_q.size() != 0) begin
        chk("cyc_ex", 32'(evt_if.evt_x), m_q[0].x);
        chk("cyc_ey", 32'(evt_if.evt_y), m_q[0].y);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic press(input int x, input int y);
    mouse_x = XW'(x);
    mouse_y = YW'(y);
    click = 1'b1;
    repeat (LAT + 1) step();
    click = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic pop_one();
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
  endtask

  typedef struct { bit nf; int mx; int my; int ex; int ey; } cur_vec_t;
  cur_vec_t tv[12];

  initial begin
    int n;
    tv[0]  = '{1, 5, 6, 5, 6};
    tv[1]  = '{0, 6, 6, 5, 6};
    tv[2]  = '{1, 6, 9, 6, 9};
    tv[3]  = '{0, 7, 9, 6, 9};
    tv[4]  = '{1, 7, 9, 7, 9};
    tv[5]  = '{1, 360, 720, 359, 719};
    tv[6]  = '{1, 400, 800, 359, 719};
    tv[7]  = '{0, 0, 0, 359, 719};
    tv[8]  = '{1, 359, 719, 359, 719};
    tv[9]  = '{1, 511, 1023, 359, 719};
    tv[10] = '{1, 0, 0, 0, 0};
    tv[11] = '{1, 100, 200, 100, 200};

    rst = 1'b1; new_frame = 1'b0; click = 1'b1;
    mouse_x = XW'(50); mouse_y = YW'(60); evt_if.evt_ready = 1'b0;

    // Reset held with click high
    repeat (2) step();
    chk("rst_cx", 32'(cursor_x), 0);
    chk("rst_cy", 32'(cursor_y), 0);
    chk("rst_valid", 32'(evt_if.evt_valid), 0);
    chk("rst_count", 32'(evt_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk_on = 1'b1;
    rst = 1'b0;
    n = 0;
    while (!evt_if.evt_valid && n < 100) begin
      step();
      n++;
    end
    chk("press_latency", 32'(n), LAT + 1);
    repeat (30) step();
    chk("press_single", 32'(evt_count), 1);
    chk("press_ex", 32'(evt_if.evt_x), 50);
    chk("press_ey", 32'(evt_if.evt_y), 60);
    pop_one();
    click = 1'b0;
    repeat (LAT + 2) step();
    chk("press_drained", 32'(evt_count), 0);

    // Short glitch, then clamped press
    click = 1'b1;
    repeat (DBC - 1) step();
    click = 1'b0;
    repeat (LAT + 2) step();
    chk("glitch_count", 32'(evt_count), GLITCH_EVTS);
    do_reset();
    mouse_x = XW'(400); mouse_y = YW'(800); click = 1'b1;
    repeat (20) step();
    chk("clamp_valid", 32'(evt_if.evt_valid), 1);
    chk("clamp_ex", 32'(evt_if.evt_x), 359);
    chk("clamp_ey", 32'(evt_if.evt_y), 719);
    click = 1'b0;
    repeat (LAT + 1) step();

    // Overflow with consumer stalled
    do_reset();
    for (int k = 0; k < 5; k++) press(10 + k, 20 + k);
    chk("ovf_count", 32'(evt_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_valid", 32'(evt_if.evt_valid), 1);
      chk("ovf_drain_x", 32'(evt_if.evt_x), 10 + k);
      chk("ovf_drain_y", 32'(evt_if.evt_y), 20 + k);
      pop_one();
    end
    chk("ovf_empty", 32'(evt_if.evt_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Full queue with pop landing on the push edge
    do_reset();
    for (int k = 0; k < 4; k++) press(30 + k, 40 + k);
    chk("fullpop_pre", 32'(evt_count), 4);
    mouse_x = XW'(99); mouse_y = YW'(98); click = 1'b1;
    for (int i = 1; i <= LAT + 1; i++) begin
      if (i == LAT + 1) evt_if.evt_ready = 1'b1;
      step();
    end
    evt_if.evt_ready = 1'b0;
    chk("fullpop_count", 32'(evt_count), 4);
    chk("fullpop_ovf", 32'(overflow), 0);
    click = 1'b0;
    repeat (LAT + 1) step();
    for (int k = 0; k < 4; k++) begin
      chk("fullpop_x", 32'(evt_if.evt_x), (k == 3) ? 99 : 31 + k);
      chk("fullpop_y", 32'(evt_if.evt_y), (k == 3) ? 98 : 41 + k);
      pop_one();
    end
    chk("fullpop_empty", 32'(evt_if.evt_valid), 0);

    // Cursor vector table
    for (int i = 0; i < 12; i++) begin
      new_frame = tv[i].nf;
      mouse_x = XW'(tv[i].mx);
      mouse_y = YW'(tv[i].my);
      step();
      chk("tbl_cx", 32'(cursor_x), tv[i].ex);
      chk("tbl_cy", 32'(cursor_y), tv[i].ey);
    end
    new_frame = 1'b0;

`ifndef CLICK_DEBOUNCE_EN
    // Single-cycle pulse without debounce
    do_reset();
    mouse_x = XW'(100); mouse_y = YW'(200); click = 1'b1;
    step();
    chk("pulse_not_yet", 32'(evt_if.evt_valid), 0);
    click = 1'b0;
    step();
    chk("pulse_valid", 32'(evt_if.evt_valid), 1);
    chk("pulse_ex", 32'(evt_if.evt_x), 100);
    chk("pulse_ey", 32'(evt_if.evt_y), 200);
    pop_one();
    chk("pulse_popped", 32'(evt_if.evt_valid), 0);
`endif

    // Randomized traffic against the model, including resets mid-press
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) click = ~click;
      mouse_x = XW'($urandom_range(0, 511));
      mouse_y = YW'($urandom_range(0, 1023));
      new_frame = ($urandom_range(0, 7) == 0);
      evt_if.evt_ready = (i < 1500) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/click_event_queue.md
# click_event_queue

Sits between the PS/2 mouse interface stage and the game processor, in the pixel clock domain. It conditions the raw click level and turns each press into one queued click event tagged with canvas coordinates. The event is held until the processor accepts it through a valid/ready handshake. It also provides a cursor position that stays stable for a whole frame, for drawing and hit-testing.

## Interface
Parameters:
- CANVAS_WIDTH, 360, horizontal canvas extent; x outputs are clamped to CANVAS_WIDTH-1.
- CANVAS_HEIGHT, 720, vertical canvas extent; y outputs are clamped to CANVAS_HEIGHT-1.
- DEPTH, 4, event FIFO entries; must be a power of two, ≥2.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before a click level change is accepted; must be ≥2.

Ports (XW = $clog2(CANVAS_WIDTH), YW = $clog2(CANVAS_HEIGHT)):
- clk_in  in  1  pixel clock; the only clock in the block.
- rst_in  in  1  synchronous, active-high reset.
- new_frame  in  1  one-cycle frame-start strobe from the video timing generator.
- mouse_x  in  XW  raw cursor x, already registered into clk_in.
- mouse_y  in  YW  raw cursor y, already registered into clk_in.
- click  in  1  raw button level, already registered into clk_in.
- cursor_x  out  XW  frame-stable clamped x.
- cursor_y  out  YW  frame-stable clamped y.
- evt_valid  out  1  FIFO non-empty; head event presented.
- evt_x  out  XW  head event x.
- evt_y  out  YW  head event y.
- evt_ready  in  1  consumer accepts the head event when it is high together with evt_valid.
- evt_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky flag; set when an event is dropped.

## Operation
- **Clamping:** cx = (mouse_x ≥ CANVAS_WIDTH) ? CANVAS_WIDTH-1 : mouse_x. cy is computed the same way against CANVAS_HEIGHT.
- **Cursor:** cursor_x/cursor_y load cx/cy on every cycle where new_frame=1, and hold otherwise.
- **Debounce:**
  - State is a registered `db` level and a counter `cnt`.
  - If click == db, cnt clears to 0.
  - If click != db, cnt increments.
  - When click != db and cnt == DEBOUNCE_CYCLES-1, db toggles and cnt clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
- **Edge detect:** db_q is db delayed by one cycle. A push request is raised when db=1 and db_q=0. Release edges are ignored.
- **Push:** writes {cx, cy}, computed from mouse_x/mouse_y in the push cycle, to the FIFO tail.
- **Pop:** happens on any cycle with evt_valid && evt_ready. The FIFO head advances.
- **FIFO structure:** circular buffer with wrapping read/write pointers and an occupancy counter.
- **Full, no pop:** a push is dropped, overflow sets, and the stored contents are unchanged.
- **Full, pop in the same cycle:** the push is accepted and occupancy stays at DEPTH.
- **Empty, push:** evt_valid rises the following cycle. There is no bypass: an event is never popped in the cycle it is pushed.
- **Empty:** evt_ready is ignored. evt_x/evt_y are don't-care while evt_valid=0.
- **Overflow:** clears only on rst_in.
- **Reset:** rst_in takes priority over every other event, including in the middle of a press.

## Timing
- **Reset values:**
  - cursor_x=0, cursor_y=0, evt_valid=0, evt_count=0, overflow=0.
  - FIFO pointers 0.
  - db=0, db_q=0, cnt=0.
  - All pending events are discarded.
- **Cursor latency:** cursor outputs update at the edge that samples new_frame=1.
- **Click latency:** click rises and is first sampled high at edge t, then held high.
  - db sets at edge t+DEBOUNCE_CYCLES-1.
  - Push occurs at edge t+DEBOUNCE_CYCLES.
  - evt_valid is high after that edge.
- **Pop:** the pop edge updates evt_count and evt_x/evt_y, and lowers evt_valid if occupancy reaches 0.
- **Throughput:** one push and one pop per cycle, at most.
- **evt_count:** reflects state after the last edge; it is a registered output.

## Configuration
- **CLICK_DEBOUNCE_EN defined:** debounce operates as described.
- **CLICK_DEBOUNCE_EN undefined:**
  - db is click registered once; the counter is removed.
  - Click sampled high at edge t gives db=1 at edge t, push at edge t+1, and evt_valid high after edge t+1.
  - All glitches of one cycle or longer produce events.

## Test plan
- **Reset:** hold rst_in for 2 cycles with click=1 → all outputs at reset values. After release, hold click=1: exactly one event, with evt_valid rising 16 edges after the first high sample (debounce enabled).
- **Glitch and clamp:**
  - click high for 15 cycles, then low → no event, evt_count=0.
  - Then mouse_x=400, mouse_y=800 with click held for 20 cycles → evt_x=359, evt_y=719.
- **Overflow:**
  - With evt_ready=0, make 5 clean presses at (10,20),(11,21),…,(14,24) → evt_count=4, overflow=1.
  - Draining returns (10,20) through (13,23) in order; then evt_valid=0.
- **Full with simultaneous pop:**
  - FIFO full; the push edge coincides with evt_valid&&evt_ready → evt_count stays 4, overflow stays 0.
  - The new event is the last one popped.
- **Cursor stability:**
  - mouse_x changes 5→6→7 between new_frame pulses → cursor_x changes only at new_frame edges.
  - Each new_frame edge loads the x value present at that edge.
- **Macro off:** one-cycle click pulse at (100,200) → an event appears 1 edge after the sample with evt_x=100, evt_y=200, and is popped in one cycle with evt_ready=1.
